// File: rtl/vm_controller_param.sv
// vm_controller_param: parametrised vending-machine controller.
// Accumulates credit from inserted coins and vends a selected product. Change is
// paid greedily, highest denomination first, from a per-denomination coin
// inventory. Also handles cancel/refund and ready/valid backpressure on both
// dispensers.
//
// Ports
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   money, money_valid          inserted coin code and its strobe
//   product_code, buy, cancel   keypad selection and single-cycle requests
//   product_ready, change_ready downstream dispenser acceptance
//   o_product_code/_valid       product handshake
//   o_change_denomination_code  change coin handshake (with o_change_valid)
//   o_busy                      controller not idle
//   o_no_change, o_coin_reject,
//   o_buy_reject                single-cycle status pulses
//   o_credit                    current credit
module vm_controller_param #(
  parameter int unsigned CODE_W       = 4,
  parameter int unsigned NUM_DENOM    = 4,
  parameter int unsigned NUM_PRODUCTS = 16,
  parameter int unsigned CREDIT_W     = 12,
  parameter int unsigned COIN_CNT_W   = 8,
  parameter logic [NUM_DENOM*CREDIT_W-1:0]    DENOM_VALUES = {12'd10, 12'd5, 12'd2, 12'd1},
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES       = {16{12'd7}},
  parameter int unsigned INIT_COINS   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CODE_W-1:0]   money,
  input  logic                money_valid,
  input  logic [CODE_W-1:0]   product_code,
  input  logic                buy,
  input  logic                cancel,
  input  logic                product_ready,
  input  logic                change_ready,
  output logic [CODE_W-1:0]   o_product_code,
  output logic                o_product_valid,
  output logic                o_busy,
  output logic [CODE_W-1:0]   o_change_denomination_code,
  output logic                o_change_valid,
  output logic                o_no_change,
  output logic                o_coin_reject,
  output logic                o_buy_reject,
  output logic [CREDIT_W-1:0] o_credit
);

  localparam int unsigned IdxW = (NUM_DENOM > 1) ? $clog2(NUM_DENOM) : 1;

  typedef enum logic [1:0] {StIdle, StCheck, StVend, StChange} state_e;

  function automatic logic [CREDIT_W-1:0] denom_value(input int unsigned i);
    return DENOM_VALUES[i*CREDIT_W +: CREDIT_W];
  endfunction

  state_e                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [CREDIT_W-1:0]   target_q, target_d;   // amount still to cover during CHECK
  logic [CREDIT_W-1:0]   price_q, price_d;
  logic [CODE_W-1:0]     product_q, product_d;
  logic                  refund_q, refund_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [COIN_CNT_W-1:0] inv_q  [NUM_DENOM];
  logic [COIN_CNT_W-1:0] inv_d  [NUM_DENOM];
  logic [COIN_CNT_W-1:0] take_q [NUM_DENOM];  // planned payout per denomination
  logic [COIN_CNT_W-1:0] take_d [NUM_DENOM];
  logic                  no_change_q, no_change_d;
  logic                  coin_reject_q, coin_reject_d;
  logic                  buy_reject_q, buy_reject_d;

  logic                  coin_ok, prod_ok, chg_any;
  logic [IdxW-1:0]       coin_idx, chg_idx;
  logic [CREDIT_W-1:0]   coin_val, prod_price, cur_val, quot, cnt, n_take, rem;
  logic [CREDIT_W:0]     credit_sum;

  always_comb begin
    coin_ok    = 32'(money) < NUM_DENOM;
    coin_idx   = money[IdxW-1:0];
    coin_val   = coin_ok ? denom_value(32'(money)) : '0;
    credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
    prod_ok    = 32'(product_code) < NUM_PRODUCTS;
    prod_price = prod_ok ? PRICES[32'(product_code)*CREDIT_W +: CREDIT_W] : '0;

    // Highest denomination with a planned coin still to pay out.
    chg_any = 1'b0;
    chg_idx = '0;
    for (int i = 0; i < NUM_DENOM; i++) begin
      if (take_q[i] != '0) begin
        chg_any = 1'b1;
        chg_idx = IdxW'(i);
      end
    end

    // Greedy step for the denomination currently under CHECK.
    cur_val = denom_value(32'(idx_q));
    quot    = (cur_val != '0) ? target_q / cur_val : '0;
    cnt     = CREDIT_W'(inv_q[idx_q]);
    n_take  = (quot < cnt) ? quot : cnt;
    rem     = target_q - n_take * cur_val;

    state_d       = state_q;
    credit_d      = credit_q;
    target_d      = target_q;
    price_d       = price_q;
    product_d     = product_q;
    refund_d      = refund_q;
    idx_d         = idx_q;
    inv_d         = inv_q;
    take_d        = take_q;
    no_change_d   = 1'b0;
    coin_reject_d = 1'b0;
    buy_reject_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (money_valid) begin
          if (coin_ok && !credit_sum[CREDIT_W] && (inv_q[coin_idx] != '1)) begin
            credit_d        = credit_sum[CREDIT_W-1:0];
            inv_d[coin_idx] = inv_q[coin_idx] + 1'b1;
          end else begin
            coin_reject_d = 1'b1;
          end
        end else if (cancel) begin
          // A cancel always suppresses a same-cycle buy, even with zero credit.
          if (credit_q != '0) begin
            target_d = credit_q;
            refund_d = 1'b1;
            idx_d    = IdxW'(NUM_DENOM - 1);
            for (int i = 0; i < NUM_DENOM; i++) take_d[i] = '0;
            state_d  = StCheck;
          end
        end else if (buy) begin
          if (!prod_ok || (prod_price > credit_q)) begin
            buy_reject_d = 1'b1;
          end else begin
            product_d = product_code;
            price_d   = prod_price;
            target_d  = credit_q - prod_price;
            refund_d  = 1'b0;
            idx_d     = IdxW'(NUM_DENOM - 1);
            for (int i = 0; i < NUM_DENOM; i++) take_d[i] = '0;
            state_d   = StCheck;
          end
        end
      end
      StCheck: begin
        take_d[idx_q] = n_take[COIN_CNT_W-1:0];
        target_d      = rem;
        if (idx_q == '0) begin
          if (rem != '0) begin
            no_change_d = 1'b1;
            state_d     = StIdle;
          end else begin
            state_d = refund_q ? StChange : StVend;
          end
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StVend: begin
        if (product_ready) begin
          credit_d = credit_q - price_q;
          state_d  = (credit_q == price_q) ? StIdle : StChange;
        end
      end
      StChange: begin
        if (!chg_any) begin
          state_d = StIdle;
        end else if (change_ready) begin
          take_d[chg_idx] = take_q[chg_idx] - 1'b1;
          inv_d[chg_idx]  = inv_q[chg_idx] - 1'b1;
          credit_d        = credit_q - denom_value(32'(chg_idx));
          if (credit_d == '0) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && money_valid) coin_reject_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      credit_q      <= '0;
      target_q      <= '0;
      price_q       <= '0;
      product_q     <= '0;
      refund_q      <= 1'b0;
      idx_q         <= '0;
      no_change_q   <= 1'b0;
      coin_reject_q <= 1'b0;
      buy_reject_q  <= 1'b0;
      for (int i = 0; i < NUM_DENOM; i++) begin
        inv_q[i]  <= COIN_CNT_W'(INIT_COINS);
        take_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      target_q      <= target_d;
      price_q       <= price_d;
      product_q     <= product_d;
      refund_q      <= refund_d;
      idx_q         <= idx_d;
      no_change_q   <= no_change_d;
      coin_reject_q <= coin_reject_d;
      buy_reject_q  <= buy_reject_d;
      inv_q         <= inv_d;
      take_q        <= take_d;
    end
  end

  always_comb begin
    o_busy                     = state_q != StIdle;
    o_product_valid            = state_q == StVend;
    o_product_code             = o_product_valid ? product_q : '0;
    o_change_valid             = (state_q == StChange) && chg_any;
    o_change_denomination_code = o_change_valid ? CODE_W'(chg_idx) : '0;
    o_no_change                = no_change_q;
    o_coin_reject              = coin_reject_q;
    o_buy_reject               = buy_reject_q;
    o_credit                   = credit_q;
  end

endmodule

// File: tb/tb_vm_controller_param.sv
module tb_vm_controller_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  money, product_code;
  logic        money_valid, buy, cancel, product_ready, change_ready;

  logic [3:0]  pcode, ccode, pcode0, ccode0;
  logic        pvalid, busy, cvalid, no_change, coin_rej, buy_rej;
  logic        pvalid0, busy0, cvalid0, no_change0, coin_rej0, buy_rej0;
  logic [11:0] credit, credit0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vm_controller_param dut (
    .clk(clk), .rst(rst), .money(money), .money_valid(money_valid),
    .product_code(product_code), .buy(buy), .cancel(cancel),
    .product_ready(product_ready), .change_ready(change_ready),
    .o_product_code(pcode), .o_product_valid(pvalid), .o_busy(busy),
    .o_change_denomination_code(ccode), .o_change_valid(cvalid),
    .o_no_change(no_change), .o_coin_reject(coin_rej), .o_buy_reject(buy_rej),
    .o_credit(credit)
  );

  // Empty inventory variant, driven by the same stimulus.
  vm_controller_param #(.INIT_COINS(0)) dut0 (
    .clk(clk), .rst(rst), .money(money), .money_valid(money_valid),
    .product_code(product_code), .buy(buy), .cancel(cancel),
    .product_ready(product_ready), .change_ready(change_ready),
    .o_product_code(pcode0), .o_product_valid(pvalid0), .o_busy(busy0),
    .o_change_denomination_code(ccode0), .o_change_valid(cvalid0),
    .o_no_change(no_change0), .o_coin_reject(coin_rej0), .o_buy_reject(buy_rej0),
    .o_credit(credit0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; money = '0; money_valid = 1'b0; product_code = '0;
    buy = 1'b0; cancel = 1'b0; product_ready = 1'b1; change_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    // Scenario A: 10 in, buy product 3 (price 7), change 2 then 1.
    do_reset();
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pvalid", pvalid, 0);
    chk("rst_cvalid", cvalid, 0);
    money = 4'd3; money_valid = 1'b1; tick(); money_valid = 1'b0;
    chk("a_credit10", credit, 10);
    chk("a_no_coin_rej", coin_rej, 0);
    product_code = 4'd3; buy = 1'b1; tick(); buy = 1'b0;
    chk("a_busy", busy, 1);
    tick(); tick(); tick();
    chk("a_pvalid_early", pvalid, 0);
    tick();
    chk("a_pvalid_t5", pvalid, 1);
    chk("a_pcode", pcode, 3);
    tick();
    chk("a_credit3", credit, 3);
    chk("a_chg1_valid", cvalid, 1);
    chk("a_chg1_code", ccode, 1);
    chk("a_pvalid_off", pvalid, 0);
    tick();
    chk("a_credit1", credit, 1);
    chk("a_chg2_code", ccode, 0);
    tick();
    chk("a_credit0", credit, 0);
    chk("a_cvalid_off", cvalid, 0);
    chk("a_idle", busy, 0);

    // Scenario B: 5 credit, price 7 -> buy reject.
    do_reset();
    money = 4'd2; money_valid = 1'b1; tick(); money_valid = 1'b0;
    product_code = 4'd0; buy = 1'b1; tick(); buy = 1'b0;
    chk("b_buy_rej", buy_rej, 1);
    chk("b_credit5", credit, 5);
    chk("b_busy", busy, 0);
    chk("b_pvalid", pvalid, 0);
    tick();
    chk("b_buy_rej_pulse", buy_rej, 0);

    // Scenario C: no-change on empty inventory; backpressure and reset mid-change.
    do_reset();
    product_ready = 1'b0; change_ready = 1'b0;
    money = 4'd3; money_valid = 1'b1; tick(); money_valid = 1'b0;
    product_code = 4'd3; buy = 1'b1; tick(); buy = 1'b0;
    tick(); tick(); tick();
    chk("c0_busy", busy0, 1);
    tick();
    chk("c0_no_change", no_change0, 1);
    chk("c0_busy_low", busy0, 0);
    chk("c0_credit10", credit0, 10);
    chk("c0_pvalid", pvalid0, 0);
    chk("c_pvalid", pvalid, 1);
    money = 4'd0; money_valid = 1'b1; tick(); money_valid = 1'b0;
    chk("c_coin_rej", coin_rej, 1);
    chk("c_credit_hold", credit, 10);
    chk("c_pvalid_hold1", pvalid, 1);
    chk("c_pcode_hold1", pcode, 3);
    chk("c0_no_change_pulse", no_change0, 0);
    tick();
    chk("c_pvalid_hold2", pvalid, 1);
    chk("c_coin_rej_pulse", coin_rej, 0);
    tick();
    chk("c_pvalid_hold3", pvalid, 1);
    chk("c_pcode_hold3", pcode, 3);
    product_ready = 1'b1; tick(); product_ready = 1'b0;
    chk("c_credit3", credit, 3);
    chk("c_cvalid", cvalid, 1);
    chk("c_ccode", ccode, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("c_cvalid_hold", cvalid, 1);
      chk("c_ccode_hold", ccode, 1);
      chk("c_credit_hold3", credit, 3);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    chk("c_rst_credit", credit, 0);
    chk("c_rst_busy", busy, 0);
    chk("c_rst_cvalid", cvalid, 0);
    chk("c_rst_ccode", ccode, 0);
    chk("c_rst_pvalid", pvalid, 0);
    chk("c_rst_inv3", dut.inv_q[3], 2);
    chk("c_rst_inv1", dut.inv_q[1], 2);

    // Scenario D: two 5s then cancel (with buy, cancel wins) -> one 10 coin refunded.
    do_reset();
    money = 4'd2; money_valid = 1'b1; tick(); tick(); money_valid = 1'b0;
    chk("d_credit10", credit, 10);
    product_code = 4'd0; cancel = 1'b1; buy = 1'b1; tick(); cancel = 1'b0; buy = 1'b0;
    chk("d_busy", busy, 1);
    tick(); tick(); tick();
    chk("d_pvalid_chk", pvalid, 0);
    tick();
    chk("d_cvalid", cvalid, 1);
    chk("d_ccode", ccode, 3);
    chk("d_pvalid", pvalid, 0);
    chk("d_credit_before", credit, 10);
    tick();
    chk("d_credit0", credit, 0);
    chk("d_idle", busy, 0);
    chk("d_cvalid_off", cvalid, 0);
    chk("d_inv3", dut.inv_q[3], 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
